// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column drive, 2-flop row sync,
// press/release debounce, one {digit, valid} pulse per accepted key press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keyPad_row,
  output logic [3:0] keyPad_column,
  output logic [3:0] digit,
  output logic       valid,
  output logic       key_held
);
  localparam int MAXC = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state, state_n;
  logic [3:0]    sync1, rs;
  logic [1:0]    col, col_n, row_idx, row_idx_n;
  logic [3:0]    pat, pat_n;
  logic [CW-1:0] dwell, dwell_n, cnt, cnt_n;
  logic [3:0]    digit_n;
  logic          valid_n, held_n;
  logic          one_low;
  logic [1:0]    low_idx;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;  4'h2: key_code = 4'h3;  4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;  4'h6: key_code = 4'h6;  4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;  4'hA: key_code = 4'h9;  4'hB: key_code = 4'hC;
      4'hC: key_code = 4'h0;  4'hD: key_code = 4'hF;  4'hE: key_code = 4'hE;  default: key_code = 4'hD;
    endcase
  endfunction

  assign keyPad_column = ~(4'b0001 << col);

  // Only a single low row is a clean press; zero or 2+ low rows are ignored.
  always_comb begin
    one_low = 1'b1;
    low_idx = 2'd0;
    case (rs)
      4'b1110: low_idx = 2'd0;
      4'b1101: low_idx = 2'd1;
      4'b1011: low_idx = 2'd2;
      4'b0111: low_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 4'hF;
      rs    <= 4'hF;
    end else begin
      sync1 <= keyPad_row;
      rs    <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SCAN;
      col      <= 2'd0;
      row_idx  <= 2'd0;
      pat      <= 4'hF;
      dwell    <= '0;
      cnt      <= '0;
      digit    <= 4'h0;
      valid    <= 1'b0;
      key_held <= 1'b0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      row_idx  <= row_idx_n;
      pat      <= pat_n;
      dwell    <= dwell_n;
      cnt      <= cnt_n;
      digit    <= digit_n;
      valid    <= valid_n;
      key_held <= held_n;
    end
  end

  always_comb begin
    state_n   = state;
    col_n     = col;
    row_idx_n = row_idx;
    pat_n     = pat;
    dwell_n   = dwell;
    cnt_n     = cnt;
    digit_n   = digit;
    valid_n   = 1'b0;
    held_n    = key_held;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_n = '0;
          if (one_low) begin
            state_n   = DEBOUNCE;
            pat_n     = rs;
            row_idx_n = low_idx;
            cnt_n     = '0;
          end else begin
            col_n = col + 2'd1;
          end
        end else begin
          dwell_n = sat_inc(dwell);
        end
      end
      DEBOUNCE: begin
        if (rs != pat) begin
          state_n = SCAN;
          dwell_n = '0;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          valid_n = 1'b1;
          digit_n = key_code(row_idx, col);
          held_n  = 1'b1;
          state_n = HELD;
          cnt_n   = '0;
        end else begin
          cnt_n = sat_inc(cnt);
        end
      end
      HELD: begin
        // Any low row, including extra keys, keeps the press alive.
        if (rs == 4'hF) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end
      end
      RELEASE: begin
        if (rs != 4'hF) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          held_n  = 1'b0;
          state_n = SCAN;
          col_n   = col + 2'd1;
          dwell_n = '0;
          cnt_n   = '0;
        end else begin
          cnt_n = sat_inc(cnt);
        end
      end
      default: state_n = SCAN;
    endcase
  end
endmodule
